// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor
//   Checks a PLL output frequency against the clkin reference. The PLL side
//   supplies pll_tick, a toggle that flips once per 128 output cycles; both
//   of its polarities are counted over a fixed gate window of clkin cycles.
//   The count is then compared against an expected value with a tolerance.
//   Measurement only runs once the PLL has reported lock and a settle delay
//   has passed. A bad window, or loss of lock while measuring, raises a
//   sticky fault.
//
// Ports
//   clkin       in   reference clock, rising edge
//   reset       in   asynchronous active-high reset
//   pll_lock    in   PLL lock indicator (asynchronous to clkin)
//   pll_tick    in   PLL divided toggle (asynchronous to clkin)
//   fault_clr   in   clears fault (a fault being set on the same cycle wins)
//   freq_count  out  edge count of the last completed window
//   count_valid out  one-cycle pulse alongside each freq_count update
//   freq_ok     out  last window within tolerance and lock held
//   fault       out  sticky fault flag
//   state       out  FSM state: IDLE=0, SETTLE=1, MEASURE=2
module pll_clk_monitor #(
  parameter int GATE_CYCLES   = 27000,
  parameter int EXP_COUNT     = 316,
  parameter int TOL           = 4,
  parameter int SETTLE_CYCLES = 2700,
  parameter int CNT_W         = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             pll_tick,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             fault,
  output logic [1:0]       state
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  // Wide enough for any count or parameter value, so the tolerance check
  // never underflows or truncates.
  localparam int XW = ((CNT_W > 32) ? CNT_W : 32) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t cur, nxt;

  logic             lock_p0, lock_p1;
  logic             tick_p0, tick_p1, tick_p2;
  logic             lock_s, tick_edge;
  logic [GW-1:0]    gate_cnt;
  logic [SW-1:0]    settle_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] win_count;
  logic             settle_done, terminal, win_ok, fault_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic in_tol(input logic [CNT_W-1:0] c);
    logic [XW-1:0] cx, ex, diff;
    cx   = XW'(c);
    ex   = XW'(EXP_COUNT);
    diff = (cx >= ex) ? (cx - ex) : (ex - cx);
    return diff <= XW'(TOL);
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: extra tick flop for edge detect
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;
      tick_p0 <= pll_tick;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  assign lock_s    = lock_p1;
  assign tick_edge = tick_p1 ^ tick_p2;

  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  // A window whose last cycle coincides with lock loss is discarded.
  assign terminal    = (cur == MEASURE) && lock_s &&
                       (gate_cnt == GW'(GATE_CYCLES - 1));
  // An edge detected on the terminal cycle belongs to the closing window.
  assign win_count   = tick_edge ? sat_inc(edge_cnt) : edge_cnt;
  assign win_ok      = in_tol(win_count);
  assign fault_set   = (cur == MEASURE) && (!lock_s || (terminal && !win_ok));

  // FSM
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (lock_s) nxt = SETTLE;
      SETTLE: begin
        if (!lock_s)          nxt = IDLE;
        else if (settle_done) nxt = MEASURE;
      end
      MEASURE: if (!lock_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign state = cur;

  // Counters and window report
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      gate_cnt    <= '0;
      settle_cnt  <= '0;
      edge_cnt    <= '0;
      freq_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (cur)
        SETTLE: begin
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          settle_cnt <= (lock_s && !settle_done) ? settle_cnt + 1'b1 : '0;
        end
        MEASURE: begin
          settle_cnt <= '0;
          if (!lock_s) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end else if (terminal) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            freq_count  <= win_count;
            count_valid <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (tick_edge) edge_cnt <= sat_inc(edge_cnt);
          end
        end
        default: begin
          gate_cnt   <= '0;
          settle_cnt <= '0;
          edge_cnt   <= '0;
        end
      endcase
    end
  end

  // Status flags
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      freq_ok <= 1'b0;
      fault   <= 1'b0;
    end else begin
      if (cur != MEASURE || !lock_s) freq_ok <= 1'b0;
      else if (terminal)             freq_ok <= win_ok;

      if (fault_set)      fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_clk_monitor.sv
module tb_pll_clk_monitor;

  logic        clk;
  logic        reset, lock, tick, sat_tick, fault_clr;
  logic [15:0] freq_count;
  logic        count_valid, freq_ok, fault;
  logic [1:0]  state;
  logic [3:0]  sat_freq_count;
  logic        sat_count_valid, sat_freq_ok, sat_fault;
  logic [1:0]  sat_state;

  int checks = 0;
  int fails  = 0;
  int period = 10;
  int tcnt   = 0;

  pll_clk_monitor #(
    .GATE_CYCLES(100), .EXP_COUNT(10), .TOL(1), .SETTLE_CYCLES(20), .CNT_W(16)
  ) dut (
    .clkin(clk), .reset(reset), .pll_lock(lock), .pll_tick(tick),
    .fault_clr(fault_clr), .freq_count(freq_count), .count_valid(count_valid),
    .freq_ok(freq_ok), .fault(fault), .state(state)
  );

  pll_clk_monitor #(
    .GATE_CYCLES(100), .EXP_COUNT(10), .TOL(1), .SETTLE_CYCLES(20), .CNT_W(4)
  ) dut_sat (
    .clkin(clk), .reset(reset), .pll_lock(lock), .pll_tick(sat_tick),
    .fault_clr(fault_clr), .freq_count(sat_freq_count),
    .count_valid(sat_count_valid), .freq_ok(sat_freq_ok), .fault(sat_fault),
    .state(sat_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the next falling edge and update the tick generators.
  task automatic cyc();
    @(negedge clk);
    sat_tick = ~sat_tick;
    if (period != 0) begin
      tcnt++;
      if (tcnt >= period) begin
        tick = ~tick;
        tcnt = 0;
      end
    end else begin
      tcnt = 0;
    end
  endtask

  task automatic wait_valid(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      cyc();
      n++;
      if (count_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_measure(input int max, output int settle_n,
                              output bit saw_valid, output bit ok);
    settle_n  = 0;
    saw_valid = 1'b0;
    ok        = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      if (count_valid) saw_valid = 1'b1;
      if (state == 2'd2)      ok = 1'b1;
      else if (state == 2'd1) settle_n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (freq_count !== 16'd0) begin fails++; $display("FAIL reset_freq_count: got %0d expected 0", freq_count); end
    checks++; if (count_valid !== 1'b0) begin fails++; $display("FAIL reset_count_valid: got %b expected 0", count_valid); end
    checks++; if (freq_ok !== 1'b0) begin fails++; $display("FAIL reset_freq_ok: got %b expected 0", freq_ok); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (sat_state !== 2'd0) begin fails++; $display("FAIL reset_sat_state: got %0d expected 0", sat_state); end
    reset = 1'b0;
    repeat (4) cyc();
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL idle_no_lock: got %0d expected 0", state); end
  endtask

  task automatic test_nominal();
    int n, sn; bit ok, sv;
    lock = 1'b1;
    wait_measure(200, sn, sv, ok);
    checks++; if (!ok || sn != 20) begin fails++; $display("FAIL nominal_settle: got %0d settle cycles (reached=%b) expected 20", sn, ok); end
    wait_valid(150, n, ok);
    checks++; if (!ok || n != 100) begin fails++; $display("FAIL nominal_first_valid: got %0d cycles (seen=%b) expected 100", n, ok); end
    checks++; if (freq_count !== 16'd10) begin fails++; $display("FAIL nominal_count: got %0d expected 10", freq_count); end
    checks++; if (freq_ok !== 1'b1) begin fails++; $display("FAIL nominal_freq_ok: got %b expected 1", freq_ok); end
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL nominal_fault: got %b expected 0", fault); end
  endtask

  task automatic test_saturation();
    bit ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      cyc();
      if (sat_count_valid) ok = 1'b1;
    end
    checks++; if (!ok || sat_freq_count !== 4'd15) begin fails++; $display("FAIL sat_count: got %0d (seen=%b) expected 15", sat_freq_count, ok); end
    checks++; if (sat_freq_ok !== 1'b0) begin fails++; $display("FAIL sat_freq_ok: got %b expected 0", sat_freq_ok); end
    checks++; if (sat_fault !== 1'b1) begin fails++; $display("FAIL sat_fault: got %b expected 1", sat_fault); end
  endtask

  task automatic test_lock_loss();
    int n, sn, idle_at; bit ok, sv, saw;
    logic [15:0] fc;
    wait_valid(150, n, ok);
    fc = freq_count;
    repeat (30) cyc();
    lock    = 1'b0;
    idle_at = 0;
    saw     = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (count_valid) saw = 1'b1;
      if (state == 2'd0 && idle_at == 0) idle_at = i;
    end
    checks++; if (idle_at < 1 || idle_at > 3) begin fails++; $display("FAIL lockloss_idle_latency: got %0d cycles expected 1..3", idle_at); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL lockloss_fault: got %b expected 1", fault); end
    checks++; if (freq_ok !== 1'b0) begin fails++; $display("FAIL lockloss_freq_ok: got %b expected 0", freq_ok); end
    checks++; if (freq_count !== fc) begin fails++; $display("FAIL lockloss_hold_count: got %0d expected %0d", freq_count, fc); end
    lock = 1'b1;
    wait_measure(200, sn, sv, ok);
    checks++; if (!ok || sn != 20) begin fails++; $display("FAIL lockloss_resettle: got %0d settle cycles (reached=%b) expected 20", sn, ok); end
    checks++; if (saw || sv) begin fails++; $display("FAIL lockloss_no_valid: got count_valid seen expected none"); end
    wait_valid(150, n, ok);
    checks++; if (!ok || n != 100 || freq_count !== 16'd10) begin fails++; $display("FAIL lockloss_rewindow: got %0d cycles count %0d expected 100 cycles count 10", n, freq_count); end
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0; cyc();
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL lockloss_fault_clr: got %b expected 0", fault); end
  endtask

  task automatic test_bad_rate();
    int n; bit ok1, ok2;
    period = 8;
    wait_valid(150, n, ok1);
    wait_valid(150, n, ok2);
    checks++; if (!ok2 || (freq_count !== 16'd12 && freq_count !== 16'd13)) begin fails++; $display("FAIL badrate_count: got %0d expected 12 or 13", freq_count); end
    checks++; if (freq_ok !== 1'b0) begin fails++; $display("FAIL badrate_freq_ok: got %b expected 0", freq_ok); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL badrate_fault: got %b expected 1", fault); end
    period = 10;
    wait_valid(150, n, ok1);
    wait_valid(150, n, ok2);
    checks++; if (!ok2 || freq_count !== 16'd10 || freq_ok !== 1'b1) begin fails++; $display("FAIL badrate_restored: got count %0d ok %b expected count 10 ok 1", freq_count, freq_ok); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL badrate_fault_sticky: got %b expected 1", fault); end
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0; cyc();
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL badrate_fault_clr: got %b expected 0", fault); end
  endtask

  task automatic test_terminal_edge();
    int n; bit ok1, ok2;
    period = 0;
    wait_valid(150, n, ok1);
    wait_valid(150, n, ok2);
    // Window boundary is now known: the next report lands 100 cycles on.
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0;
    checks++; if (fault !== 1'b0) begin fails++; $display("FAIL term_pre_clear: got %b expected 0", fault); end
    for (int j = 2; j <= 99; j++) begin
      cyc();
      if ((j <= 18 && j % 2 == 0) || j == 97) tick = ~tick;
    end
    cyc();
    checks++; if (count_valid !== 1'b1 || freq_count !== 16'd10) begin fails++; $display("FAIL term_edge_counted: got valid %b count %0d expected valid 1 count 10", count_valid, freq_count); end
    checks++; if (freq_ok !== 1'b1 || fault !== 1'b0) begin fails++; $display("FAIL term_window_ok: got ok %b fault %b expected ok 1 fault 0", freq_ok, fault); end
    for (int j = 101; j <= 199; j++) cyc();
    fault_clr = 1'b1;
    cyc();
    fault_clr = 1'b0;
    checks++; if (count_valid !== 1'b1 || freq_count !== 16'd0) begin fails++; $display("FAIL term_next_starts_zero: got valid %b count %0d expected valid 1 count 0", count_valid, freq_count); end
    checks++; if (fault !== 1'b1) begin fails++; $display("FAIL term_set_beats_clr: got %b expected 1", fault); end
    period = 10;
    wait_valid(150, n, ok1);
    wait_valid(150, n, ok2);
    fault_clr = 1'b1; cyc(); fault_clr = 1'b0; cyc();
    checks++; if (freq_count !== 16'd10 || fault !== 1'b0) begin fails++; $display("FAIL term_recover: got count %0d fault %b expected count 10 fault 0", freq_count, fault); end
  endtask

  task automatic test_async_reset();
    int n, sn; bit ok, sv;
    repeat (40) cyc();
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || count_valid !== 1'b0) begin fails++; $display("FAIL areset_state: got state %0d valid %b expected 0 0", state, count_valid); end
    checks++; if (freq_count !== 16'd0 || sat_freq_count !== 4'd0) begin fails++; $display("FAIL areset_count: got %0d/%0d expected 0/0", freq_count, sat_freq_count); end
    checks++; if (freq_ok !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL areset_flags: got ok %b fault %b expected 0 0", freq_ok, fault); end
    cyc();
    reset = 1'b0;
    wait_measure(200, sn, sv, ok);
    checks++; if (!ok || sn != 20 || sv) begin fails++; $display("FAIL areset_resettle: got %0d settle cycles valid_seen %b expected 20 and none", sn, sv); end
    wait_valid(150, n, ok);
    checks++; if (!ok || n != 100 || freq_count !== 16'd10) begin fails++; $display("FAIL areset_first_window: got %0d cycles count %0d expected 100 cycles count 10", n, freq_count); end
  endtask

  initial begin
    reset     = 1'b1;
    lock      = 1'b0;
    tick      = 1'b0;
    sat_tick  = 1'b0;
    fault_clr = 1'b0;
    test_reset();
    test_nominal();
    test_saturation();
    test_lock_loss();
    test_bad_rate();
    test_terminal_edge();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
